// File: rtl/rr_onehot_arbiter_pkg.sv
// Shared constants for the round-robin arbiter and the one-hot coder it feeds.
package rr_onehot_arbiter_pkg;

  localparam int N_DEFAULT = 1024;
  localparam int M_DEFAULT = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_masked_pick.sv
// Combinational round-robin winner search: lowest request at/above ptr,
// else lowest request overall. Output is one-hot, or zero when req is zero.
module rr_masked_pick
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] ptr_i,
  output logic [N-1:0] winner_o
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] w_therm;
  logic [N-1:0] w_masked;
  logic [N-1:0] w_masked_lsb;
  logic [N-1:0] w_plain_lsb;

  // ptr is one-hot, so ~(ptr-1) sets every bit at or above it
  assign w_therm      = ~(ptr_i - ONE);
  assign w_masked     = req_i & w_therm;
  assign w_masked_lsb = w_masked & (~w_masked + ONE);
  assign w_plain_lsb  = req_i & (~req_i + ONE);

  assign winner_o = (|w_masked) ? w_masked_lsb : w_plain_lsb;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter issuing a registered one-hot grant held until ack,
// then rotating priority to the requester just past the winner.
module rr_onehot_arbiter
  import rr_onehot_arbiter_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         enable_i,
  input  logic [N-1:0] req_i,
  input  logic         ack_i,
  output logic [N-1:0] grant_o,
  output logic         valid_o
);

  localparam logic [N-1:0] PTR_RESET  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] GRANT_NONE = {N{1'b0}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_ptr;
  logic [N-1:0] r_grant;
  logic         r_valid;
  logic [N-1:0] w_ptr_nxt;
  logic [N-1:0] w_grant_nxt;
  logic         w_valid_nxt;
  logic [N-1:0] w_winner;
  logic         w_arb_go;

  rr_masked_pick #(.N(N)) u_pick (
    .req_i    (req_i),
    .ptr_i    (r_ptr),
    .winner_o (w_winner)
  );

  assign w_arb_go = enable_i & (|req_i);

  // State, pointer and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_RESET;
      r_grant <= GRANT_NONE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_go) w_state_nxt = ST_GRANT;
        else          w_state_nxt = ST_IDLE;
      end
      ST_GRANT: begin
        if (ack_i) w_state_nxt = ST_IDLE;
        else       w_state_nxt = ST_GRANT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next grant/valid/pointer values; the grant is locked while waiting for ack
  always_comb begin
    w_grant_nxt = r_grant;
    w_valid_nxt = r_valid;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_arb_go) begin
          w_grant_nxt = w_winner;
          w_valid_nxt = 1'b1;
        end else begin
          w_grant_nxt = GRANT_NONE;
          w_valid_nxt = 1'b0;
        end
      end
      ST_GRANT: begin
        if (ack_i) begin
          w_grant_nxt = GRANT_NONE;
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = {r_grant[N-2:0], r_grant[N-1]};
        end else begin
          w_grant_nxt = r_grant;
          w_valid_nxt = r_valid;
        end
      end
      default: begin
        w_grant_nxt = GRANT_NONE;
        w_valid_nxt = 1'b0;
        w_ptr_nxt   = PTR_RESET;
      end
    endcase
  end

  assign grant_o = r_grant;
  assign valid_o = r_valid;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench: directed vector table plus randomized run against an
// index-based round-robin model; grant is also decoded to a coder index.
module tb_rr_onehot_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n_i;
  logic         enable_i;
  logic [N-1:0] req_i;
  logic         ack_i;
  logic [N-1:0] grant_o;
  logic         valid_o;

  int n_checks = 0;
  int n_errors = 0;

  rr_onehot_arbiter #(.N(N)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n_i),
    .enable_i (enable_i),
    .req_i    (req_i),
    .ack_i    (ack_i),
    .grant_o  (grant_o),
    .valid_o  (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst_n;
    logic         en;
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] exp_grant;
    logic         exp_valid;
    logic [N-1:0] exp_ptr;
    int           exp_idx;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rst_n, logic en, logic [N-1:0] req, logic ack,
                              logic [N-1:0] eg, logic ev, logic [N-1:0] ep, int ei);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.req = req; v.ack = ack;
    v.exp_grant = eg; v.exp_valid = ev; v.exp_ptr = ep; v.exp_idx = ei;
    vecs.push_back(v);
  endfunction

  // Downstream one-hot-to-binary coder stand-in
  function automatic int coder_idx(logic [N-1:0] g);
    for (int k = 0; k < N; k++) if (g[k]) return k;
    return 0;
  endfunction

  // Reference winner: scan from ptr index upward with wrap
  function automatic int model_pick(logic [N-1:0] req, int p);
    for (int o = 0; o < N; o++) if (req[(p + o) % N]) return (p + o) % N;
    return -1;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m_ptr;
  int m_gidx;
  bit m_busy;

  initial begin
    rst_n_i = 1'b0; enable_i = 1'b1; req_i = 8'hFF; ack_i = 1'b0;

    // reset held two cycles, then first grant
    add(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h01, 0);
    add(1'b0, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 8'h01, 0);
    add(1'b1, 1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 8'h01, 0);
    add(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h02, 0);
    // rotation with wrap
    for (int k = 1; k < N; k++) begin
      add(1'b1, 1'b1, 8'hFF, 1'b0, 8'(1 << k), 1'b1, 8'(1 << k), k);
      add(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'(1 << ((k + 1) % N)), 0);
    end
    add(1'b1, 1'b1, 8'hFF, 1'b0, 8'h01, 1'b1, 8'h01, 0);
    add(1'b1, 1'b1, 8'hFF, 1'b1, 8'h00, 1'b0, 8'h02, 0);
    // skip and wrap from ptr=6
    add(1'b1, 1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 8'h02, 5);
    add(1'b1, 1'b1, 8'h20, 1'b1, 8'h00, 1'b0, 8'h40, 0);
    add(1'b1, 1'b1, 8'h09, 1'b0, 8'h01, 1'b1, 8'h40, 0);
    add(1'b1, 1'b1, 8'h09, 1'b1, 8'h00, 1'b0, 8'h02, 0);
    add(1'b1, 1'b1, 8'h09, 1'b0, 8'h08, 1'b1, 8'h02, 3);
    add(1'b1, 1'b1, 8'h09, 1'b1, 8'h00, 1'b0, 8'h10, 0);
    // hold while req drops and enable low; ack honoured with enable low
    add(1'b1, 1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 8'h10, 2);
    for (int k = 0; k < 5; k++) add(1'b1, 1'b0, 8'h00, 1'b0, 8'h04, 1'b1, 8'h10, 2);
    add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h08, 0);
    // enable gating
    for (int k = 0; k < 4; k++) add(1'b1, 1'b0, 8'h10, 1'b0, 8'h00, 1'b0, 8'h08, 0);
    add(1'b1, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1, 8'h08, 4);
    add(1'b1, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 8'h20, 0);
    // ack in IDLE ignored
    add(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h20, 0);
    // reset mid-grant with simultaneous ack
    add(1'b1, 1'b1, 8'h20, 1'b0, 8'h20, 1'b1, 8'h20, 5);
    add(1'b0, 1'b1, 8'h20, 1'b1, 8'h00, 1'b0, 8'h01, 0);
    add(1'b1, 1'b1, 8'h21, 1'b0, 8'h01, 1'b1, 8'h01, 0);
    add(1'b1, 1'b1, 8'h21, 1'b1, 8'h00, 1'b0, 8'h02, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n_i = vecs[i].rst_n; enable_i = vecs[i].en;
      req_i = vecs[i].req; ack_i = vecs[i].ack;
      tick();
      chk($sformatf("vec%0d grant", i), int'(grant_o), int'(vecs[i].exp_grant));
      chk($sformatf("vec%0d valid", i), int'(valid_o), int'(vecs[i].exp_valid));
      chk($sformatf("vec%0d ptr", i), int'(dut.r_ptr), int'(vecs[i].exp_ptr));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d coder", i), coder_idx(grant_o), vecs[i].exp_idx);
    end

    // randomized run against the index model (state: IDLE, ptr index 1)
    m_ptr = 1; m_busy = 1'b0; m_gidx = 0;
    for (int c = 0; c < 400; c++) begin
      rst_n_i  = ($urandom_range(0, 49) != 0);
      enable_i = ($urandom_range(0, 3) != 0);
      req_i    = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      ack_i    = $urandom_range(0, 1) == 1;
      if (!rst_n_i) begin
        m_busy = 1'b0; m_ptr = 0;
      end else if (m_busy) begin
        if (ack_i) begin
          m_busy = 1'b0; m_ptr = (m_gidx + 1) % N;
        end
      end else if (enable_i && req_i != 8'h00) begin
        m_gidx = model_pick(req_i, m_ptr); m_busy = 1'b1;
      end
      tick();
      chk("rand grant", int'(grant_o), m_busy ? (1 << m_gidx) : 0);
      chk("rand valid", int'(valid_o), int'(m_busy));
      chk("rand ptr", int'(dut.r_ptr), 1 << m_ptr);
      chk("rand onehot0", int'($onehot0(grant_o)), 1);
      if (m_busy) chk("rand coder", coder_idx(grant_o), m_gidx);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
